// File: rtl/score_digit_render.sv
// score_digit_render: draws the two-digit BCD score as two scaled 8x8 glyphs.
// The score is sampled once per frame at position (0,0), so a score change
// part-way through a frame cannot tear the digits.
// Pixel path: 2-cycle fixed latency.
//   Stage 1 does the box test and works out cell, glyph row and glyph column.
//   Stage 2 does the glyph ROM lookup and registers oPixOn.
// Optional feature: define SCORE_BLINK_EN to make the digits flicker for
// BLINK_FRAMES frames after a score change.
module score_digit_render #(
  parameter int H_TOT        = 800,
  parameter int V_TOT        = 525,
  parameter int X0           = 296,
  parameter int Y0           = 16,
  parameter int SCALE_LOG2   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic [7:0]               iScore,
  input  logic [$clog2(H_TOT)-1:0] iHPos,
  input  logic [$clog2(V_TOT)-1:0] iVPos,
  output logic                     oPixOn,
  output logic [7:0]               oFrameScore
);

  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int CELL_W = 8 << SCALE_LOG2;

  localparam logic [HW-1:0] X0_H    = HW'(X0);
  localparam logic [VW-1:0] Y0_V    = VW'(Y0);
  localparam logic [HW-1:0] BOX_W_H = HW'(2 * CELL_W);
  localparam logic [VW-1:0] BOX_H_V = VW'(CELL_W);

  // Returns one 8-bit glyph row, with the leftmost column in bit 7.
  // The 5x7 font sits in columns 1..5. Row 7 is blank. Nibbles 10-15 are blank.
  function automatic logic [7:0] glyph_row(input logic [3:0] nib, input logic [2:0] row);
    logic [4:0] f;
    case ({nib, row})
      7'h00: f = 5'b01110; 7'h01: f = 5'b10001; 7'h02: f = 5'b10011; 7'h03: f = 5'b10101;
      7'h04: f = 5'b11001; 7'h05: f = 5'b10001; 7'h06: f = 5'b01110;
      7'h08: f = 5'b00100; 7'h09: f = 5'b01100; 7'h0A: f = 5'b00100; 7'h0B: f = 5'b00100;
      7'h0C: f = 5'b00100; 7'h0D: f = 5'b00100; 7'h0E: f = 5'b01110;
      7'h10: f = 5'b01110; 7'h11: f = 5'b10001; 7'h12: f = 5'b00001; 7'h13: f = 5'b00010;
      7'h14: f = 5'b00100; 7'h15: f = 5'b01000; 7'h16: f = 5'b11111;
      7'h18: f = 5'b11111; 7'h19: f = 5'b00010; 7'h1A: f = 5'b00100; 7'h1B: f = 5'b00010;
      7'h1C: f = 5'b00001; 7'h1D: f = 5'b10001; 7'h1E: f = 5'b01110;
      7'h20: f = 5'b00010; 7'h21: f = 5'b00110; 7'h22: f = 5'b01010; 7'h23: f = 5'b10010;
      7'h24: f = 5'b11111; 7'h25: f = 5'b00010; 7'h26: f = 5'b00010;
      7'h28: f = 5'b11111; 7'h29: f = 5'b10000; 7'h2A: f = 5'b11110; 7'h2B: f = 5'b00001;
      7'h2C: f = 5'b00001; 7'h2D: f = 5'b10001; 7'h2E: f = 5'b01110;
      7'h30: f = 5'b00110; 7'h31: f = 5'b01000; 7'h32: f = 5'b10000; 7'h33: f = 5'b11110;
      7'h34: f = 5'b10001; 7'h35: f = 5'b10001; 7'h36: f = 5'b01110;
      7'h38: f = 5'b11111; 7'h39: f = 5'b00001; 7'h3A: f = 5'b00010; 7'h3B: f = 5'b00100;
      7'h3C: f = 5'b01000; 7'h3D: f = 5'b01000; 7'h3E: f = 5'b01000;
      7'h40: f = 5'b01110; 7'h41: f = 5'b10001; 7'h42: f = 5'b10001; 7'h43: f = 5'b01110;
      7'h44: f = 5'b10001; 7'h45: f = 5'b10001; 7'h46: f = 5'b01110;
      7'h48: f = 5'b01110; 7'h49: f = 5'b10001; 7'h4A: f = 5'b10001; 7'h4B: f = 5'b01111;
      7'h4C: f = 5'b00001; 7'h4D: f = 5'b00010; 7'h4E: f = 5'b01100;
      default: f = 5'b00000;
    endcase
    return {1'b0, f, 2'b00};
  endfunction

  logic            frame_start_s;
  logic [HW-1:0]   dx_s;
  logic [VW-1:0]   dy_s;
  logic [7:0]      snap_q, snap_d;
  logic            in_box_q, in_box_d;
  logic            sel_ones_q, sel_ones_d;
  logic [3:0]      nib_q, nib_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      col_q, col_d;
  logic [7:0]      glyph_s;
  logic            mask_s;
  logic            pix_q, pix_d;

  assign frame_start_s = (iHPos == {HW{1'b0}}) && (iVPos == {VW{1'b0}});
  assign dx_s          = iHPos - X0_H;
  assign dy_s          = iVPos - Y0_V;

  // Next snapshot: take the live score only at the frame-start position.
  always_comb begin
    if (frame_start_s) begin
      snap_d = iScore;
    end else begin
      snap_d = snap_q;
    end
  end

  // Stage 1 decode: box test, cell select, glyph row and column from the offsets.
  always_comb begin
    in_box_d   = (iHPos >= X0_H) && (dx_s < BOX_W_H) && (iVPos >= Y0_V) && (dy_s < BOX_H_V);
    sel_ones_d = dx_s[SCALE_LOG2 + 3];
    col_d      = dx_s[SCALE_LOG2 + 2 -: 3];
    row_d      = dy_s[SCALE_LOG2 + 2 -: 3];
    if (sel_ones_d) begin
      nib_d = snap_q[3:0];
    end else begin
      nib_d = snap_q[7:4];
    end
  end

  // Stage 2 pixel: ROM row lookup and column pick.
  // A zero tens digit is blanked so that a single-digit score has no leading zero.
  always_comb begin
    glyph_s = glyph_row(nib_q, row_q);
    if (!in_box_q || mask_s) begin
      pix_d = 1'b0;
    end else if (!sel_ones_q && (nib_q == 4'd0)) begin
      pix_d = 1'b0;
    end else begin
      pix_d = glyph_s[3'd7 - col_q];
    end
  end

  // Snapshot and both pipeline stages; all of them are cleared by reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      snap_q     <= 8'h00;
      in_box_q   <= 1'b0;
      sel_ones_q <= 1'b0;
      nib_q      <= 4'h0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      pix_q      <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      in_box_q   <= in_box_d;
      sel_ones_q <= sel_ones_d;
      nib_q      <= nib_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_q, blink_d;

  // Blink counter: a score change at frame start reloads it.
  // Otherwise it counts down once per frame until it reaches zero.
  always_comb begin
    if (frame_start_s && (iScore != snap_q)) begin
      blink_d = BW'(BLINK_FRAMES);
    end else if (frame_start_s && (blink_q != {BW{1'b0}})) begin
      blink_d = blink_q - {{(BW-1){1'b0}}, 1'b1};
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink counter register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      blink_q <= {BW{1'b0}};
    end else begin
      blink_q <= blink_d;
    end
  end

  // Counter bit 2 gives 4 frames on and 4 frames off while the blink runs.
  assign mask_s = (blink_q != {BW{1'b0}}) && blink_q[2];
`else
  // Without the blink feature the mask is constant low.
  // BLINK_FRAMES is never negative, so this compare is always false.
  assign mask_s = (BLINK_FRAMES < 32'sd0);
`endif

  assign oPixOn      = pix_q;
  assign oFrameScore = snap_q;

endmodule

// File: tb/tb_score_digit_render.sv
// Directed bench for score_digit_render with its default parameters.
// The bench expects the blink feature to be compiled out.
// Geometry with the default parameters:
//   tens cell x = 296..327, ones cell x = 328..359, both cells y = 16..47.
//   Each glyph cell spans 4x4 pixels.
module tb_score_digit_render;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [7:0] iScore;
  logic [9:0] iHPos;
  logic [9:0] iVPos;
  logic       oPixOn;
  logic [7:0] oFrameScore;

  int   errors = 0;
  int   checks = 0;
  logic pe;
  bit   pvalid;
  int   ph;
  int   pv;

  score_digit_render dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iScore      (iScore),
    .iHPos       (iHPos),
    .iVPos       (iVPos),
    .oPixOn      (oPixOn),
    .oFrameScore (oFrameScore)
  );

  always #5 iClk = ~iClk;

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Present one position for one clock.
  // After the clock edge, oPixOn holds the result for the previous call's position.
  task automatic cyc(input int h, input int v, input logic e);
    @(negedge iClk);
    iHPos = 10'(h);
    iVPos = 10'(v);
    @(posedge iClk);
    #1;
    if (pvalid) begin
      checks++;
      assert (oPixOn === pe) else begin
        errors++;
        $error("FAIL pix h=%0d v=%0d got=%b exp=%b", ph, pv, oPixOn, pe);
      end
    end
    pe = e;
    pvalid = 1'b1;
    ph = h;
    pv = v;
  endtask

  task automatic flush();
    cyc(700, 500, 1'b0);
    cyc(700, 500, 1'b0);
  endtask

  task automatic frame(input logic [7:0] s);
    iScore = s;
    cyc(0, 0, 1'b0);
    chk8("frame_snap", oFrameScore, s);
  endtask

  initial begin
    iRst_n = 1'b0;
    iScore = 8'h42;
    iHPos  = 10'd700;
    iVPos  = 10'd500;
    pvalid = 1'b0;
    pe     = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk1("rst_pix", oPixOn, 1'b0);
    chk8("rst_score", oFrameScore, 8'h00);
    @(negedge iClk);
    iRst_n = 1'b1;
    pvalid = 1'b1;
    pe = 1'b0;
    ph = 700;
    pv = 500;

    // The first frame start captures 42.
    // Tens digit 4, row 0 is 00010, so column 4 (x=312) is lit.
    // Ones digit 2, row 0 is 01110, so column 1 (x=332) is dark and column 2 (x=336) is lit.
    frame(8'h42);
    cyc(312, 16, 1'b1);
    cyc(332, 16, 1'b0);
    cyc(336, 16, 1'b1);
    flush();

    // Score 07: the tens cell is fully dark (leading-zero blank).
    // Ones row 0 is 11111, so x=332..351 is lit.
    frame(8'h07);
    for (int y = 16; y < 48; y++)
      for (int x = 296; x < 328; x++)
        cyc(x, y, 1'b0);
    for (int x = 326; x < 355; x++)
      cyc(x, 16, (x >= 332) && (x <= 351));
    flush();

    // Score 88: geometry edges and exact 2-cycle latency.
    // Rows 0 and 6 are 01110; row 1 is 10001; row 7 is blank.
    frame(8'h88);
    cyc(295, 16, 1'b0);
    cyc(296, 16, 1'b0);
    cyc(360, 16, 1'b0);
    cyc(304, 16, 1'b1);
    cyc(336, 16, 1'b1);
    cyc(359, 16, 1'b0);
    cyc(304, 47, 1'b0);
    cyc(304, 48, 1'b0);
    cyc(304, 15, 1'b0);
    cyc(304, 40, 1'b1);
    cyc(316, 20, 1'b1);
    cyc(320, 20, 1'b0);
    cyc(328, 16, 1'b0);
    flush();

    // Score 00 shows a single "0" in the ones cell.
    frame(8'h00);
    cyc(304, 16, 1'b0);
    cyc(336, 16, 1'b1);
    cyc(332, 16, 1'b0);
    flush();

    // Mid-frame change: 12 stays on screen until the next frame start.
    // At (348,24): digit 2, row 2 is 00001, so lit; digit 3, row 2 is 00100, so dark.
    // At (332,16): digit 2, row 0 column 1 is dark; digit 3, row 0 column 1 is lit.
    frame(8'h12);
    cyc(308, 16, 1'b1);
    cyc(332, 16, 1'b0);
    iScore = 8'h13;
    cyc(700, 100, 1'b0);
    cyc(0, 5, 1'b0);
    cyc(5, 0, 1'b0);
    chk8("mid_hold", oFrameScore, 8'h12);
    cyc(332, 16, 1'b0);
    cyc(348, 24, 1'b1);
    flush();
    frame(8'h13);
    cyc(332, 16, 1'b1);
    cyc(348, 24, 1'b0);
    cyc(308, 16, 1'b1);
    flush();

    // Invalid BCD: both cells are blank across the whole box.
    frame(8'hAF);
    for (int y = 16; y < 48; y++)
      for (int x = 296; x < 360; x++)
        cyc(x, y, 1'b0);
    flush();

    // Reset mid-frame: outputs drop at once.
    // The snapshot stays 00 until the next frame start.
    frame(8'h88);
    cyc(304, 16, 1'b1);
    cyc(304, 16, 1'b1);
    chk1("pre_rst_pix", oPixOn, 1'b1);
    iScore = 8'h55;
    iRst_n = 1'b0;
    #1;
    chk1("midrst_pix", oPixOn, 1'b0);
    chk8("midrst_score", oFrameScore, 8'h00);
    @(negedge iClk);
    iRst_n = 1'b1;
    pvalid = 1'b1;
    pe = 1'b0;
    cyc(304, 16, 1'b0);
    cyc(336, 16, 1'b1);
    cyc(312, 16, 1'b0);
    flush();
    chk8("post_rst_score", oFrameScore, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_digit_render.md
Name: score_digit_render

Overview:
- Downstream consumer of the 2-digit BCD game score `{tens, ones}` produced by the score counter.
- Rasterises the score as two scaled 8x8 glyphs at a fixed screen location, driven by the VGA timing counters.
- Output is a 1-bit "score pixel on" flag that the pixel mux ORs over the game scene.
- The score is snapshotted once per frame so a mid-frame increment never tears the digits.

Parameters:
- H_TOT, 800, total horizontal count per line (sets iHPos width = $clog2(H_TOT)).
- V_TOT, 525, total lines per frame (sets iVPos width = $clog2(V_TOT)).
- X0, 296, left pixel column of the tens digit.
- Y0, 16, top line of both digits.
- SCALE_LOG2, 2, glyph magnification exponent; each glyph cell is (8<<SCALE_LOG2) pixels square.
- BLINK_FRAMES, 30, number of frames the blink runs after a score change (optional feature only).

Ports:
- iClk  in  1  pixel clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iScore  in  8  BCD score: [7:4] tens, [3:0] ones.
- iHPos  in  $clog2(H_TOT)  current horizontal counter.
- iVPos  in  $clog2(V_TOT)  current vertical counter.
- oPixOn  out  1  1 = draw score colour at the pixel addressed 2 cycles earlier.
- oFrameScore  out  8  score snapshot currently being displayed.

Behaviour:
- Reset: iRst_n low asynchronously clears all registers.
  - oPixOn=0, oFrameScore=8'h00, pipeline stages cleared, blink state idle.
- Snapshot:
  - On a rising iClk with iHPos==0 and iVPos==0, rSnap <= iScore.
  - oFrameScore = rSnap.
  - Changes of iScore at any other time have no visible effect until the next frame start.
- Geometry: W = 8<<SCALE_LOG2.
  - Tens cell: x in [X0, X0+W), y in [Y0, Y0+W).
  - Ones cell: x in [X0+W, X0+2W), same y range.
  - Glyph column = (x-cellX)>>SCALE_LOG2 (0..7); glyph row = (y-Y0)>>SCALE_LOG2 (0..7).
  - Subtractions are done at iHPos/iVPos width; comparisons are unsigned.
- Pipeline (fixed latency 2 cycles):
  - Stage 1 registers: inBox, digit-select, BCD nibble from rSnap, glyph row, glyph column.
  - Stage 2 does the glyph-ROM row lookup (combinational case on {nibble,row}, 8-bit row pattern), selects bit [7-col], and registers oPixOn.
  - oPixOn at cycle n+2 reflects iHPos/iVPos presented at cycle n.
  - Throughput is one pixel per cycle with no stalls.
- Glyphs:
  - Digits 0-9 use a 5x7 font centred in the 8x8 cell; row 7 and columns 0, 6, 7 are blank.
  - Nibble values 10-15 render blank.
- Leading-zero blanking: if tens==0, the tens cell renders blank; the ones digit is always shown, so score 00 shows "0".
- Out of box: oPixOn=0.
- Boundary conditions:
  - Cells clipped by H_TOT/V_TOT are simply not drawn; there is no wrap.
  - Snapshot at frame start and a simultaneous iScore change: the new iScore value is captured.
- Reset mid-frame: outputs are 0 immediately. The snapshot stays 00 until the next frame start, even if iScore is non-zero.

Optional Feature:
- Macro: SCORE_BLINK_EN.
- Defined:
  - At each frame start, if the new snapshot differs from the previous one, a frame counter loads BLINK_FRAMES.
  - The counter decrements once per frame start until 0.
  - While the counter is non-zero, oPixOn is forced 0 on frames where counter bit 2 is 1, giving a 4-on/4-off flicker.
  - Reset clears the counter.
  - A further change during a blink reloads the counter.
- Undefined: no counter exists and oPixOn is never masked.

Test Plan:
- Reset then frame: hold iRst_n=0 for 3 clocks with iScore=8'h42 → oPixOn=0 and oFrameScore=00. After release and the first (0,0) position, oFrameScore=8'h42.
- Render ones digit: iScore=8'h07, step a frame.
  - At glyph-row 0 of the ones cell, oPixOn goes high 2 cycles after the first lit column position.
  - The tens cell stays dark throughout (leading-zero blank).
- Latency/geometry: drive (X0-1,Y0), (X0,Y0), (X0+2W,Y0) with score 8'h88 → oPixOn matches the model exactly 2 cycles later. The position X0+2W is 0.
- Mid-frame change: score 8'h12 latched, then iScore=8'h13 at line 100 → the rest of the frame still draws "12"; the next frame draws "13".
- Invalid BCD: iScore=8'hAF → both cells blank for the whole frame.
- (SCORE_BLINK_EN) Score 8'h05→8'h06 at a frame boundary:
  - Digits are masked on the frames where counter bit 2 is 1, for 30 frames.
  - From frame 31 onward the digits are steady.
